// File: rtl/alu_pkg.sv
// Shared definitions for the vector ALU issue stage: function codes, lane
// widths, issue FSM states and the multi-cycle op classifier.
package alu_pkg;

  localparam logic [5:0] VAND   = 6'b000001;
  localparam logic [5:0] VOR    = 6'b000010;
  localparam logic [5:0] VXOR   = 6'b000011;
  localparam logic [5:0] VNOT   = 6'b000100;
  localparam logic [5:0] VMOV   = 6'b000101;
  localparam logic [5:0] VADD   = 6'b000110;
  localparam logic [5:0] VSUB   = 6'b000111;
  localparam logic [5:0] VMULEU = 6'b001000;
  localparam logic [5:0] VMULOU = 6'b001001;
  localparam logic [5:0] VSLL   = 6'b001010;
  localparam logic [5:0] VSRL   = 6'b001011;
  localparam logic [5:0] VSRA   = 6'b001100;
  localparam logic [5:0] VRTTH  = 6'b001101;
  localparam logic [5:0] VDIV   = 6'b001110;
  localparam logic [5:0] VMOD   = 6'b001111;
  localparam logic [5:0] VSQEU  = 6'b010000;
  localparam logic [5:0] VSQOU  = 6'b010001;
  localparam logic [5:0] VSQRT  = 6'b010010;

  localparam logic [1:0] WW_8  = 2'b00;
  localparam logic [1:0] WW_16 = 2'b01;
  localparam logic [1:0] WW_32 = 2'b10;
  localparam logic [1:0] WW_64 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } issue_state_e;

  // Ops whose operands must stay on the ALU inputs for several cycles.
  function automatic logic is_multicycle(input logic [5:0] r_ins);
    return (r_ins == VDIV) || (r_ins == VMOD) || (r_ins == VSQRT);
  endfunction

endpackage

// File: rtl/alu_fwd_mux.sv
// Priority forwarding mux for one source operand: EX result, then WB data,
// then the register-file read. WB forwarding exists only when
// ALU_ISSUE_WB_FWD_EN is defined; otherwise the wb_* inputs are ignored.
module alu_fwd_mux #(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] src_addr,
  input  logic              ex_fwd_ok,
  input  logic [ADDR_W-1:0] ex_rd_addr,
  input  logic [0:63]       alu_out,
  input  logic              wb_wr_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [0:63]       wb_data,
  input  logic [0:63]       rf_val,
  output logic [0:63]       fwd_val
);

`ifdef ALU_ISSUE_WB_FWD_EN
  localparam logic WB_FWD = 1'b1;
`else
  localparam logic WB_FWD = 1'b0;
`endif

  logic ex_hit;
  logic wb_hit;

  // Select the youngest producer of src_addr; EX beats WB.
  always_comb begin
    ex_hit  = ex_fwd_ok && (ex_rd_addr == src_addr);
    wb_hit  = WB_FWD && wb_wr_en && (wb_addr == src_addr);
    fwd_val = rf_val;
    if (ex_hit) begin
      fwd_val = alu_out;
    end else if (wb_hit) begin
      fwd_val = wb_data;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-to-execute register for the vector ALU. Handles valid/ready issue,
// RAW forwarding (EX, and WB when ALU_ISSUE_WB_FWD_EN is defined), operand
// hold for multi-cycle ops, and the result-valid strobe for writeback.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int MC_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:63]       in_rA_val,
  input  logic [0:63]       in_rB_val,
  input  logic [ADDR_W-1:0] in_rA_addr,
  input  logic [ADDR_W-1:0] in_rB_addr,
  input  logic [ADDR_W-1:0] in_rd_addr,
  input  logic [0:5]        in_R_ins,
  input  logic [0:1]        in_WW,
  input  logic              in_Op_code,
  input  logic              in_wr_en,
  input  logic [0:63]       alu_out,
  input  logic              wb_wr_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [0:63]       wb_data,
  output logic [0:63]       ex_rA_val,
  output logic [0:63]       ex_rB_val,
  output logic [0:5]        ex_R_ins,
  output logic [0:1]        ex_WW,
  output logic              ex_Op_code,
  output logic [ADDR_W-1:0] ex_rd_addr,
  output logic              ex_wr_en,
  output logic              ex_valid,
  output logic              ex_result_valid
);

  localparam int CNT_W = (MC_LAT < 2) ? 1 : $clog2(MC_LAT + 1);

  issue_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [0:63]       ex_rA_val_q, ex_rA_val_d;
  logic [0:63]       ex_rB_val_q, ex_rB_val_d;
  logic [0:5]        ex_R_ins_q, ex_R_ins_d;
  logic [0:1]        ex_WW_q, ex_WW_d;
  logic              ex_Op_code_q, ex_Op_code_d;
  logic [ADDR_W-1:0] ex_rd_addr_q, ex_rd_addr_d;
  logic              ex_wr_en_q, ex_wr_en_d;

  logic              last_cycle;
  logic              accept;
  logic              ex_fwd_ok;
  logic [0:63]       fwd_a, fwd_b;

  // Handshake and status are pure functions of the current state.
  always_comb begin
    last_cycle      = (state_q == ST_HOLD) && (cnt_q == CNT_W'(1));
    in_ready        = !flush && ((state_q != ST_HOLD) || (cnt_q == CNT_W'(1)));
    accept          = in_valid && in_ready;
    ex_valid        = (state_q != ST_IDLE);
    ex_result_valid = (state_q == ST_RUN) || last_cycle;
    ex_fwd_ok       = ex_valid && ex_wr_en_q && ex_result_valid;
  end

  alu_fwd_mux #(.ADDR_W(ADDR_W)) u_fwd_a (
    .src_addr  (in_rA_addr),
    .ex_fwd_ok (ex_fwd_ok),
    .ex_rd_addr(ex_rd_addr_q),
    .alu_out   (alu_out),
    .wb_wr_en  (wb_wr_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .rf_val    (in_rA_val),
    .fwd_val   (fwd_a)
  );

  alu_fwd_mux #(.ADDR_W(ADDR_W)) u_fwd_b (
    .src_addr  (in_rB_addr),
    .ex_fwd_ok (ex_fwd_ok),
    .ex_rd_addr(ex_rd_addr_q),
    .alu_out   (alu_out),
    .wb_wr_en  (wb_wr_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .rf_val    (in_rB_val),
    .fwd_val   (fwd_b)
  );

  // Next state and EX register contents; data fields change only on accept.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ex_rA_val_d  = ex_rA_val_q;
    ex_rB_val_d  = ex_rB_val_q;
    ex_R_ins_d   = ex_R_ins_q;
    ex_WW_d      = ex_WW_q;
    ex_Op_code_d = ex_Op_code_q;
    ex_rd_addr_d = ex_rd_addr_q;
    ex_wr_en_d   = ex_wr_en_q;

    if (flush) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      ex_wr_en_d = 1'b0;
    end else if (accept) begin
      ex_rA_val_d  = fwd_a;
      ex_rB_val_d  = fwd_b;
      ex_R_ins_d   = in_R_ins;
      ex_WW_d      = in_WW;
      ex_Op_code_d = in_Op_code;
      ex_rd_addr_d = in_rd_addr;
      ex_wr_en_d   = in_wr_en && in_Op_code;
      // MC_LAT of 1 collapses a multi-cycle op into an ordinary RUN cycle.
      if (in_Op_code && is_multicycle(in_R_ins) && (MC_LAT > 1)) begin
        state_d = ST_HOLD;
        cnt_d   = CNT_W'(MC_LAT);
      end else begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    end else if ((state_q == ST_HOLD) && (cnt_q > CNT_W'(1))) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      ex_wr_en_d = 1'b0;
    end
  end

  // State and EX registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ex_rA_val_q  <= '0;
      ex_rB_val_q  <= '0;
      ex_R_ins_q   <= '0;
      ex_WW_q      <= '0;
      ex_Op_code_q <= 1'b0;
      ex_rd_addr_q <= '0;
      ex_wr_en_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ex_rA_val_q  <= ex_rA_val_d;
      ex_rB_val_q  <= ex_rB_val_d;
      ex_R_ins_q   <= ex_R_ins_d;
      ex_WW_q      <= ex_WW_d;
      ex_Op_code_q <= ex_Op_code_d;
      ex_rd_addr_q <= ex_rd_addr_d;
      ex_wr_en_q   <= ex_wr_en_d;
    end
  end

  assign ex_rA_val  = ex_rA_val_q;
  assign ex_rB_val  = ex_rB_val_q;
  assign ex_R_ins   = ex_R_ins_q;
  assign ex_WW      = ex_WW_q;
  assign ex_Op_code = ex_Op_code_q;
  assign ex_rd_addr = ex_rd_addr_q;
  assign ex_wr_en   = ex_wr_en_q;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode-to-execute pipeline register feeding the combinational vector ALU: rA_64bit_val, rB_64bit_val, R_ins, Op_code, WW.
- Accepts one decoded vector instruction per cycle over a valid/ready handshake.
- Resolves RAW hazards by forwarding from ALU_out and from the writeback port.
- Holds operands stable for multi-cycle ops (VDIV, VMOD, VSQRT). Generates a result-valid strobe for the writeback stage.

Parameters:
- ADDR_W, 5, register-file address width.
- MC_LAT, 4, cycles that VDIV/VMOD/VSQRT operands are held (≥1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  kill the instruction in EX; drop any input offered this cycle.
- in_valid  in  1  decode has an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_rA_val  in  64 [0:63]  register-file read of rA, bit 0 is MSB.
- in_rB_val  in  64 [0:63]  register-file read of rB.
- in_rA_addr, in_rB_addr, in_rd_addr  in  ADDR_W  source and destination addresses.
- in_R_ins  in  6 [0:5]  ALU function code.
- in_WW  in  2 [0:1]  lane width: 00=8b, 01=16b, 10=32b, 11=64b.
- in_Op_code  in  1  1 = vector ALU op.
- in_wr_en  in  1  instruction writes rd.
- alu_out  in  64 [0:63]  ALU_out from the ALU driven by this stage.
- wb_wr_en  in  1  writeback is writing this cycle.
- wb_addr  in  ADDR_W  writeback address.
- wb_data  in  64  writeback data.
- ex_rA_val, ex_rB_val  out  64 [0:63]  registered operands to the ALU.
- ex_R_ins  out  6.
- ex_WW  out  2.
- ex_Op_code  out  1.
- ex_rd_addr  out  ADDR_W.
- ex_wr_en  out  1  = in_wr_en & in_Op_code, captured at accept.
- ex_valid  out  1  an instruction occupies EX.
- ex_result_valid  out  1  alu_out is final this cycle; WB captures it.

Behaviour:
- Reset: all ex_* outputs 0; ex_valid=0; ex_result_valid=0; hold counter 0. in_ready=1 after reset (combinational).
- Multi-cycle set: R_ins ∈ {001110 VDIV, 001111 VMOD, 010010 VSQRT} with Op_code=1. All other codes are single-cycle.
- States:
  - IDLE: EX empty.
  - RUN: single-cycle op in EX.
  - HOLD: multi-cycle op in EX, counter cnt counting down.
- Accept = in_valid & in_ready & ~flush.
  - in_ready = ~flush & (state≠HOLD | cnt==1).
  - A new instruction may enter in the last HOLD cycle (back-to-back).
- On accept, capture all in_* fields. Next state: HOLD with cnt=MC_LAT if multi-cycle (MC_LAT=1 behaves as RUN), else RUN.
- No accept from RUN or IDLE → IDLE. HOLD with cnt>1 → cnt decrements; outputs frozen.
- ex_valid=1 in RUN and HOLD.
- ex_result_valid=1 in RUN, or in HOLD when cnt==1. Combinational from state, so exactly one pulse per instruction.
- Forwarding, evaluated separately for rA and rB at accept:
  1. If ex_valid & ex_wr_en & ex_rd_addr==src_addr & ex_result_valid → alu_out.
  2. Else if wb_wr_en & wb_addr==src_addr → wb_data.
  3. Else the register-file value.
- EX match while a HOLD is not yet final cannot occur, because in_ready is low then.
- Address 0 is an ordinary register, with no special casing.
- Load-after-op in the same cycle: EX forwarding takes priority over WB.
- flush: next state IDLE; ex_valid and ex_wr_en cleared; cnt cleared. Operand registers may keep stale data. A flush with in_valid drops the input (in_ready=0).
- rst_n assertion mid-HOLD: immediate return to reset values, regardless of clk.
- in_valid low: ex_* data registers retain their values; only ex_valid and ex_wr_en clear.

Optional Feature:
- ALU_ISSUE_WB_FWD_EN.
  - Defined: WB-stage forwarding (priority 2) is present.
  - Undefined: the wb_* ports still exist but are ignored; only EX forwarding happens. Decode must then stall externally on WB hazards.

Decomposition:
- Shared package alu_pkg:
  - R_ins localparams: VAND=000001, VOR=000010, VXOR=000011, VNOT=000100, VMOV=000101, VADD=000110, VSUB=000111, VMULEU=001000, VMULOU=001001, VSLL=001010, VSRL=001011, VSRA=001100, VRTTH=001101, VDIV=001110, VMOD=001111, VSQEU=010000, VSQOU=010001, VSQRT=010010.
  - WW encodings.
  - State encoding.
  - is_multicycle(R_ins) function.
- One sub-module: alu_fwd_mux, the priority forwarding mux, instantiated once for rA and once for rB.

Test Plan:
1. Reset, then issue VAND with rA=64'd15, rB=64'd14 → next cycle ex_R_ins=000001, ex_valid=1, ex_result_valid=1; ALU output 64'd14.
2. VADD WW=11 to rd=3 (rA=FFFFFFFF_FFFFFFFF, rB=00000000_11111111), then back-to-back VMOV with rA_addr=3 and a stale RF value 0 → ex_rA_val=00000000_11111110, forwarded from alu_out.
3. VDIV WW=00 (rA=FF123456_78786345, rB=FFFF3401_FFDE3211), MC_LAT=4, with in_valid held high → in_ready low for 3 cycles; ex_* stable for 4 cycles; single ex_result_valid pulse in cycle 4; next op accepted in cycle 4.
4. WB writes r5=64'h5 while decode issues VMOV with rA_addr=5 and RF value 0 → ex_rA_val=64'h5 with ALU_ISSUE_WB_FWD_EN; 0 without it.
5. flush asserted during VMOD HOLD cnt=2 with in_valid high → next cycle ex_valid=0, ex_wr_en=0, input not accepted; following cycle in_ready=1.
6. rst_n pulsed low mid-HOLD between clock edges → ex_valid, ex_result_valid and all ex_* outputs read 0 immediately.
